// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum trailer is enabled by IM_LOADER_CHECKSUM_EN.
package im_loader_pkg;

  localparam int unsigned IM_DEPTH_DEFAULT = 4096;
  localparam logic [31:0] IM_BASE_ADDR     = 32'h0000_3000;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_SUM  = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/im_byte_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes in and flags the 4th byte.
// The completed word is presented combinationally on the edge that accepts its last byte.
module im_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for the shift register and byte counter.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (shift_i) begin
      shreg_d = {shreg_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  // Packer state registers; the counter wraps so it realigns for the next word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= 24'h00_0000;
      cnt_q   <= 2'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o      = {shreg_q, byte_i};
  assign word_done_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Boot loader: length-prefixed byte stream -> sequential IM word writes, holds CPU in reset.
// Define IM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum of all data words.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [31:0]       idx_q, idx_d;
  logic [31:0]       len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_s, accept_s, word_done_s;
  logic [31:0]       word_s;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  // Ready is a pure state decode so there is no path from byte_valid.
  always_comb begin
    case (state_q)
      S_LEN, S_DATA, S_SUM: ready_s = 1'b1;
      default:              ready_s = 1'b0;
    endcase
  end

  assign accept_s = byte_valid && ready_s;

  im_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .shift_i     (accept_s),
    .byte_i      (byte_data),
    .word_o      (word_s),
    .word_done_o (word_done_s)
  );

  // Load sequencer: next state, word index, and output register inputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_LEN: begin
        if (word_done_s) begin
          len_d = word_s;
          if (word_s > 32'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (word_s == 32'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = S_SUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (word_done_s) begin
          we_d    = 1'b1;
          waddr_d = idx_q[ADDR_W-1:0];
          wdata_d = word_s;
          idx_d   = idx_q + 32'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word_s;
`endif
          if (idx_q == (len_q - 32'd1)) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = S_SUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_SUM: begin
`ifdef IM_LOADER_CHECKSUM_EN
        if (word_done_s) begin
          if (word_s == sum_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_SUM;
        end
`else
        // Unreachable without the checksum trailer; fail safe.
        state_d = S_ERR;
        err_d   = 1'b1;
`endif
      end
      S_FIN: begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restores the idle, CPU-held condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LEN;
      idx_q       <= 32'd0;
      len_q       <= 32'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  // Running modular sum of data words for the trailer compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  assign byte_ready = ready_s;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        exp_we;
    logic [11:0] exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_ready;
    logic        exp_done;
    logic        exp_cpu_reset;
    logic        exp_err;
  } vec_t;

  im_loader #(.DEPTH(4096), .ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every IM write away from the active edge.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 3; b >= 0; b--) begin
      byte_valid = 1'b0;
      byte_data  = 8'hA5;
      repeat ($urandom_range(max_gap, 0)) tick();
      byte_valid = 1'b1;
      byte_data  = w[b*8 +: 8];
      tick();
    end
    byte_valid = 1'b0;
  endtask

  vec_t vt[14];

  initial begin
    logic [31:0] gw[3];
    logic [31:0] gsum;

    vt[0]  = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 8'h02, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 8'h3C, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 8'h01, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'h12, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 8'h34, 1'b1, 12'h000, 32'h3C01_1234, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 8'h00, 1'b1, 12'h001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b1, 8'hFF, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) tick();
    chk("rst_we",        we,         32'd0);
    chk("rst_waddr",     waddr,      32'd0);
    chk("rst_wdata",     wdata,      32'd0);
    chk("rst_cpu_reset", cpu_reset,  32'd1);
    chk("rst_done",      done,       32'd0);
    chk("rst_err",       err,        32'd0);
    chk("rst_ready",     byte_ready, 32'd1);
    reset = 1'b0;
    tick();

`ifndef IM_LOADER_CHECKSUM_EN
    // N=2 at full rate, one record per clock.
    for (int i = 0; i < 14; i++) begin
      byte_valid = vt[i].valid;
      byte_data  = vt[i].data;
      tick();
      chk($sformatf("vec%0d_we", i),        we,         vt[i].exp_we);
      chk($sformatf("vec%0d_ready", i),     byte_ready, vt[i].exp_ready);
      chk($sformatf("vec%0d_done", i),      done,       vt[i].exp_done);
      chk($sformatf("vec%0d_cpu_reset", i), cpu_reset,  vt[i].exp_cpu_reset);
      chk($sformatf("vec%0d_err", i),       err,        vt[i].exp_err);
      if (vt[i].exp_we) begin
        chk($sformatf("vec%0d_waddr", i), waddr, vt[i].exp_waddr);
        chk($sformatf("vec%0d_wdata", i), wdata, vt[i].exp_wdata);
      end
    end
    byte_valid = 1'b0;
`endif

    // N=0: no writes, completes.
    do_reset();
    send_word(32'h0000_0000, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_word(32'h0000_0000, 0);
`endif
    chk("n0_fin_done", done, 32'd0);
    tick();
    chk("n0_done",      done,           32'd1);
    chk("n0_cpu_reset", cpu_reset,      32'd0);
    chk("n0_writes",    wr_addr.size(), 32'd0);

    // N=4097: rejected after the 4th length byte.
    do_reset();
    send_word(32'h0000_1001, 0);
    chk("big_err",       err,        32'd1);
    chk("big_ready",     byte_ready, 32'd0);
    chk("big_cpu_reset", cpu_reset,  32'd1);
    send_word(32'h1234_5678, 0);
    tick();
    chk("big_err_sticky", err,            32'd1);
    chk("big_done",       done,           32'd0);
    chk("big_writes",     wr_addr.size(), 32'd0);

    // N=3 with random byte_valid gaps.
    do_reset();
    gw[0] = 32'hA1B2_C3D4;
    gw[1] = 32'h0102_0304;
    gw[2] = 32'hFFEE_DDCC;
    gsum  = 32'd0;
    send_word(32'h0000_0003, 3);
    for (int i = 0; i < 3; i++) begin
      send_word(gw[i], 3);
      gsum = gsum + gw[i];
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_word(gsum, 3);
`endif
    tick();
    chk("gap_done",   done,           32'd1);
    chk("gap_err",    err,            32'd0);
    chk("gap_writes", wr_addr.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr.size()) begin
        chk($sformatf("gap_addr%0d", i), wr_addr[i], i);
        chk($sformatf("gap_data%0d", i), wr_data[i], gw[i]);
      end
    end

    // Reset after 6 data bytes, then a fresh N=1 stream.
    do_reset();
    send_word(32'h0000_0002, 0);
    send_word(32'h1122_3344, 0);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    tick();
    tick();
    byte_valid = 1'b0;
    chk("mid_pre_wdata", wdata, 32'h1122_3344);
    reset = 1'b1;
    #1;
    chk("mid_we",        we,         32'd0);
    chk("mid_waddr",     waddr,      32'd0);
    chk("mid_wdata",     wdata,      32'd0);
    chk("mid_cpu_reset", cpu_reset,  32'd1);
    chk("mid_done",      done,       32'd0);
    chk("mid_err",       err,        32'd0);
    chk("mid_ready",     byte_ready, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    wr_addr.delete();
    wr_data.delete();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF, 0);
`endif
    tick();
    chk("re_done",   done,           32'd1);
    chk("re_writes", wr_addr.size(), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("re_addr", wr_addr[0], 32'd0);
      chk("re_data", wr_data[0], 32'hDEAD_BEEF);
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Checksum wraps modulo 2^32: good and bad trailers.
    do_reset();
    send_word(32'h0000_0002, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0001, 0);
    tick();
    chk("sum_ok_done", done, 32'd1);
    chk("sum_ok_err",  err,  32'd0);
    do_reset();
    send_word(32'h0000_0002, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0002, 0);
    tick();
    chk("sum_bad_err",       err,       32'd1);
    chk("sum_bad_done",      done,      32'd0);
    chk("sum_bad_cpu_reset", cpu_reset, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
